alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// ============================================================================
// alu_issue : single-entry issue stage between decode, one FU and writeback.
// Optional WAIT watchdog enabled by ALU_ISSUE_TIMEOUT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module alu_issue #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int RD_W           = 5
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [63:0]     i_req_op1,
  input  logic [63:0]     i_req_op2,
  input  logic [RD_W-1:0] i_req_rd,
  output logic            o_alu_start,
  output logic [63:0]     o_alu_op1,
  output logic [63:0]     o_alu_op2,
  input  logic            i_alu_done,
  input  logic [63:0]     i_alu_result,
  output logic            o_wb_valid,
  input  logic            i_wb_ready,
  output logic [63:0]     o_wb_result,
  output logic [RD_W-1:0] o_wb_rd,
  output logic            o_busy,
  output logic            o_timeout
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("alu_issue: TIMEOUT_CYCLES must be within 2..255");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [63:0]     op1_q, op1_d;
  logic [63:0]     op2_q, op2_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic [63:0]     result_q, result_d;

`ifdef ALU_ISSUE_TIMEOUT_EN
  localparam logic [7:0] TERM_CNT = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      op1_q    <= 64'h0;
      op2_q    <= 64'h0;
      rd_q     <= '0;
      result_q <= 64'h0;
`ifdef ALU_ISSUE_TIMEOUT_EN
      cnt_q     <= 8'h0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      rd_q     <= rd_d;
      result_q <= result_d;
`ifdef ALU_ISSUE_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    rd_d        = rd_q;
    result_d    = result_q;
    o_req_ready = 1'b0;
    o_alu_start = 1'b0;
    o_wb_valid  = 1'b0;
`ifdef ALU_ISSUE_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          op1_d   = i_req_op1;
          op2_d   = i_req_op2;
          rd_d    = i_req_rd;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        o_alu_start = 1'b1;
        state_d     = S_WAIT;
`ifdef ALU_ISSUE_TIMEOUT_EN
        cnt_d = 8'h0;
`endif
      end
      S_WAIT: begin
        // A completion on the terminal-count cycle wins over the watchdog.
        if (i_alu_done) begin
          result_d = i_alu_result;
          state_d  = S_WB;
        end
`ifdef ALU_ISSUE_TIMEOUT_EN
        else if (cnt_q == TERM_CNT) begin
          result_d  = 64'h0;
          timeout_d = 1'b1;
          state_d   = S_WB;
        end else begin
          cnt_d = cnt_q + 8'h1;
        end
`endif
      end
      S_WB: begin
        o_wb_valid = 1'b1;
        if (i_wb_ready) begin
          // Accepting here skips the IDLE bubble between operations.
          o_req_ready = 1'b1;
          if (i_req_valid) begin
            op1_d   = i_req_op1;
            op2_d   = i_req_op2;
            rd_d    = i_req_rd;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_alu_op1   = op1_q;
  assign o_alu_op2   = op2_q;
  assign o_wb_result = result_q;
  assign o_wb_rd     = rd_q;
  assign o_busy      = (state_q != S_IDLE);

`ifdef ALU_ISSUE_TIMEOUT_EN
  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

endmodule

`default_nettype wire
